// File: rtl/spi_slave_char_trx.sv
// spi_slave_char_trx -- SPI slave character transceiver.
//
// Receives one character per frame from an external SPI master on MOSI while
// returning a parallel-loaded character on MISO. SCK, CS and MOSI are
// oversampled in the system clock domain through 2-FF synchronizers, so every
// bus action lands 3 sysclk after the physical SCK edge.
//
// Mode fields (CPOL, CPHA, REV, LEN) are latched when select asserts and held
// for the whole frame. Characters are 1..16 bits, right-aligned in S_WCHAR and
// S_RCHAR.
//
// Optional feature macro: SPI_SLAVE_MISO_TRISTATE_EN
//   defined   -> MISO floats (1'bz) while not selected, for shared MISO lines
//   undefined -> MISO drives 1'b1 while not selected
module spi_slave_char_trx #(
    parameter int CHAR_NBITS = 32
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_CSPOL,
    input  logic                  S_REV,
    input  logic [3:0]            S_CHAR_LEN,
    input  logic                  S_SPI_CS,
    input  logic                  S_SPI_SCK,
    input  logic                  S_SPI_MOSI,
    output logic                  S_SPI_MISO,
    output logic                  S_CHAR_DONE,
    input  logic [CHAR_NBITS-1:0] S_WCHAR,
    output logic [CHAR_NBITS-1:0] S_RCHAR
);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    // Mask covering bits [len:0] of a 16-bit character.
    function automatic logic [15:0] char_mask(input logic [3:0] len);
        logic [16:0] m;
        m = (17'd1 << ({1'b0, len} + 5'd1)) - 17'd1;
        return m[15:0];
    endfunction

    // Bit that goes on the wire first for the current shift register contents.
    function automatic logic first_bit(input logic [15:0] v, input logic rev,
                                       input logic [3:0] len);
        return rev ? v[len] : v[0];
    endfunction

    // Drop the bit just presented so the next one sits in the output position.
    function automatic logic [15:0] shift_out(input logic [15:0] v, input logic rev);
        return rev ? {v[14:0], 1'b0} : {1'b0, v[15:1]};
    endfunction

    // Synchronizers and edge history
    logic cs_meta, cs_sync;
    logic sck_meta, sck_sync, sck_prev;
    logic mosi_meta, mosi_sync;

    // Frame state
    state_t      state_q, state_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic        rev_q, rev_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] tx_sr_q, tx_sr_d;
    logic [15:0] rx_sr_q, rx_sr_d;
    logic        miso_q, miso_d;
    logic        reload_q, reload_d;
    logic [CHAR_NBITS-1:0] rchar_q, rchar_d;
    logic        done_q, done_d;

    logic        selected;
    logic        sck_edge, lead_edge, trail_edge;
    logic        sample_en, shift_en;
    logic [15:0] load_live, load_frame;
    logic [3:0]  rx_idx;
    logic        unused_wchar;

    // Only S_WCHAR[15:0] can ever be transmitted; the rest is deliberately ignored.
    assign unused_wchar = ^S_WCHAR;

    assign selected   = S_ENABLE & (cs_sync == ~S_CSPOL);
    assign sck_edge   = sck_sync ^ sck_prev;
    assign lead_edge  = sck_edge & (sck_prev == cpol_q);
    assign trail_edge = sck_edge & (sck_sync == cpol_q);
    assign sample_en  = cpha_q ? trail_edge : lead_edge;
    assign shift_en   = cpha_q ? lead_edge  : trail_edge;

    // Load value seen at select assertion uses the live mode inputs; reloads
    // within a frame use the latched length.
    assign load_live  = S_WCHAR[15:0] & char_mask(S_CHAR_LEN);
    assign load_frame = S_WCHAR[15:0] & char_mask(len_q);

    // Register stage: synchronizers, edge history and frame state.
    always_ff @(posedge S_SYSCLK) begin
        // NOTE: non-blocking assignments everywhere in clocked logic, so every
        // register samples pre-edge values regardless of statement order.
        if (!S_RESETN) begin
            cs_meta   <= S_CSPOL;
            cs_sync   <= S_CSPOL;
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            state_q   <= ST_IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            rev_q     <= 1'b0;
            len_q     <= 4'd0;
            bit_cnt_q <= 4'd0;
            tx_sr_q   <= 16'd0;
            rx_sr_q   <= 16'd0;
            miso_q    <= 1'b1;
            reload_q  <= 1'b0;
            rchar_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            cs_meta   <= S_SPI_CS;
            cs_sync   <= cs_meta;
            sck_meta  <= S_SPI_SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= S_SPI_MOSI;
            mosi_sync <= mosi_meta;
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            rev_q     <= rev_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            miso_q    <= miso_d;
            reload_q  <= reload_d;
            rchar_q   <= rchar_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: frame start, bit sampling, MISO shifting, completion and abort.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves a value unassigned, which would infer a latch.
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        rev_d     = rev_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        miso_d    = miso_q;
        reload_d  = reload_q;
        rchar_d   = rchar_q;
        done_d    = 1'b0;
        rx_idx    = rev_q ? (len_q - bit_cnt_q) : bit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Select assertion wins over any SCK edge in the same cycle.
                if (selected) begin
                    state_d   = ST_XFER;
                    cpol_d    = S_CPOL;
                    cpha_d    = S_CPHA;
                    rev_d     = S_REV;
                    len_d     = S_CHAR_LEN;
                    bit_cnt_d = 4'd0;
                    reload_d  = 1'b0;
                    if (S_CPHA) begin
                        // First bit goes out on the first leading edge.
                        tx_sr_d = load_live;
                    end else begin
                        // First bit must be on MISO before any SCK edge.
                        miso_d  = first_bit(load_live, S_REV, S_CHAR_LEN);
                        tx_sr_d = shift_out(load_live, S_REV);
                    end
                end
            end

            ST_XFER: begin
                if (!selected) begin
                    // Abort: drop the partial character, keep S_RCHAR.
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                    reload_d  = 1'b0;
                end else begin
                    if (sample_en) begin
                        rx_sr_d[rx_idx] = mosi_sync;
                        if (bit_cnt_q == len_q) begin
                            bit_cnt_d = 4'd0;
                            done_d    = 1'b1;
                            rchar_d   = CHAR_NBITS'(rx_sr_d & char_mask(len_q));
                            if (cpha_q) begin
                                tx_sr_d = load_frame;
                            end else begin
                                // Reload is presented on the following trailing edge.
                                reload_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    if (shift_en) begin
                        if (!cpha_q && reload_q) begin
                            miso_d   = first_bit(load_frame, rev_q, len_q);
                            tx_sr_d  = shift_out(load_frame, rev_q);
                            reload_d = 1'b0;
                        end else begin
                            miso_d   = first_bit(tx_sr_q, rev_q, len_q);
                            tx_sr_d  = shift_out(tx_sr_q, rev_q);
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign S_CHAR_DONE = done_q;
    assign S_RCHAR     = rchar_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign S_SPI_MISO = selected ? miso_q : 1'bz;
`else
    assign S_SPI_MISO = selected ? miso_q : 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave_char_trx.sv
// tb_spi_slave_char_trx -- directed bench for spi_slave_char_trx.
// A bus-functional SPI master drives frames; expected S_RCHAR values are queued
// at stimulus time and a monitor pops one per S_CHAR_DONE pulse.
module tb_spi_slave_char_trx;

    localparam int SCK_HALF = 8;  // sysclk cycles per SCK phase

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
    localparam logic [15:0] IDLE_BYTE = 16'h00zz;
`else
    localparam logic MISO_IDLE = 1'b1;
    localparam logic [15:0] IDLE_BYTE = 16'h00ff;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cpol;
    logic        cpha;
    logic        cspol;
    logic        rev;
    logic [3:0]  char_len;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        char_done;
    logic [31:0] wchar;
    logic [31:0] rchar;

    int          checks;
    int          errors;
    int          done_count;
    logic [31:0] exp_q[$];

    spi_slave_char_trx #(.CHAR_NBITS(32)) dut (
        .S_SYSCLK   (clk),
        .S_RESETN   (rst_n),
        .S_ENABLE   (enable),
        .S_CPOL     (cpol),
        .S_CPHA     (cpha),
        .S_CSPOL    (cspol),
        .S_REV      (rev),
        .S_CHAR_LEN (char_len),
        .S_SPI_CS   (spi_cs),
        .S_SPI_SCK  (spi_sck),
        .S_SPI_MOSI (spi_mosi),
        .S_SPI_MISO (spi_miso),
        .S_CHAR_DONE(char_done),
        .S_WCHAR    (wchar),
        .S_RCHAR    (rchar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every S_CHAR_DONE cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && char_done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got S_RCHAR=%h, expected no S_CHAR_DONE", rchar);
            end else begin
                check("rchar_on_done", rchar, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        spi_sck = cpol;
        wait_clk(SCK_HALF);
        spi_cs = ~cspol;
        wait_clk(SCK_HALF);
    endtask

    task automatic frame_end();
        wait_clk(SCK_HALF);
        spi_cs = cspol;
        wait_clk(SCK_HALF);
    endtask

    // Shift nbits of one character; returns what the master saw on MISO.
    task automatic xfer_char(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        int idx;
        rx = 16'd0;
        for (int i = 0; i < nbits; i++) begin
            idx = rev ? (int'(char_len) - i) : i;
            if (!cpha) begin
                spi_mosi = tx[idx];
                wait_clk(SCK_HALF);
                rx[idx] = spi_miso;
                spi_sck = ~cpol;
                wait_clk(SCK_HALF);
                spi_sck = cpol;
            end else begin
                spi_sck = ~cpol;
                spi_mosi = tx[idx];
                wait_clk(SCK_HALF);
                rx[idx] = spi_miso;
                spi_sck = cpol;
                wait_clk(SCK_HALF);
            end
        end
    endtask

    // Full character with a queued S_RCHAR expectation and a MISO check.
    task automatic send_char(input string tag, input logic [15:0] tx,
                             input logic [31:0] exp_rchar, input logic [15:0] exp_miso);
        logic [15:0] rx;
        exp_q.push_back(exp_rchar);
        xfer_char(tx, int'(char_len) + 1, rx);
        check(tag, {16'd0, rx}, {16'd0, exp_miso});
    endtask

    initial begin
        logic [15:0] rx;
        checks     = 0;
        errors     = 0;
        done_count = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b1;
        cspol    = 1'b1;
        rev      = 1'b1;
        char_len = 4'd7;
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        wchar    = 32'h1faa1234;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);

        // Reset and idle
        check("reset_rchar", rchar, 32'h0);
        check("reset_done", {31'd0, char_done}, 32'h0);
        check("reset_miso", {31'd0, spi_miso}, {31'd0, MISO_IDLE});
        for (int i = 0; i < 16; i++) begin
            spi_sck = ~spi_sck;
            wait_clk(SCK_HALF);
        end
        spi_sck = 1'b0;
        wait_clk(SCK_HALF);
        check("idle_no_done", done_count, 0);

        // CPOL0 CPHA1 MSB-first 8-bit single character
        frame_start();
        send_char("miso_single", 16'h0001, 32'h00000001, 16'h0034);
        frame_end();
        check("single_done_count", done_count, 1);

        // Four back-to-back characters in one frame
        frame_start();
        send_char("miso_b2b_0", 16'h0001, 32'h00000001, 16'h0034);
        send_char("miso_b2b_1", 16'h0002, 32'h00000002, 16'h0034);
        send_char("miso_b2b_2", 16'h0003, 32'h00000003, 16'h0034);
        send_char("miso_b2b_3", 16'h0004, 32'h00000004, 16'h0034);
        frame_end();
        check("b2b_done_count", done_count, 5);

        // CPOL1 CPHA0 LSB-first 16-bit
        cpol     = 1'b1;
        cpha     = 1'b0;
        rev      = 1'b0;
        char_len = 4'd15;
        frame_start();
        send_char("miso_cpha0_16b", 16'hA55A, 32'h0000A55A, 16'h1234);
        frame_end();
        check("cpha0_done_count", done_count, 6);

        // Abort after 3 of 8 bits, then a full character
        cpol     = 1'b0;
        cpha     = 1'b1;
        rev      = 1'b1;
        char_len = 4'd7;
        frame_start();
        xfer_char(16'h00FF, 3, rx);
        frame_end();
        check("abort_no_done", done_count, 6);
        check("abort_rchar_held", rchar, 32'h0000A55A);
        frame_start();
        send_char("miso_after_abort", 16'h00C3, 32'h000000C3, 16'h0034);
        frame_end();
        check("after_abort_done_count", done_count, 7);

        // Disabled: bus ignored, MISO idle
        enable = 1'b0;
        frame_start();
        xfer_char(16'h005A, 8, rx);
        frame_end();
        check("disabled_miso_idle", {16'd0, rx}, {16'd0, IDLE_BYTE});
        check("disabled_no_done", done_count, 7);
        check("disabled_rchar_held", rchar, 32'h000000C3);
        enable = 1'b1;

        wait_clk(20);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
